// File: rtl/dca_xmi_port_arbiter_pkg.sv
`default_nettype none
// ============================================================
// dca_xmi_port_arbiter_pkg : shared widths, states and helpers
// Revision: 1.0
// ============================================================
package dca_xmi_port_arbiter_pkg;

  localparam int c_BW_LEN   = 8;
  localparam int c_BW_SIZE  = 3;
  localparam int c_BW_BURST = 2;
  localparam int c_BW_RESP  = 2;

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Requester ID sits just above the upstream burden bits.
  function automatic int f_id_bit(input int bw_burden);
    return bw_burden;
  endfunction

  function automatic int f_down_burden(input int bw_burden);
    return bw_burden + 1;
  endfunction

  function automatic int f_cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dca_xmi_port_arbiter_if.sv
`default_nettype none
// ============================================================
// dca_xmi_port_arbiter_if : LPI request/response bundle
// Revision: 1.0
// ============================================================
interface dca_xmi_port_arbiter_if
  import dca_xmi_port_arbiter_pkg::*;
#(
  parameter int BW_AXI_ADDR = 32,
  parameter int BW_AXI_DATA = 32,
  parameter int BW_BURDEN   = 1
);

  logic                     qvalid;
  logic                     qready;
  logic                     qlast;
  logic                     qwrite;
  logic [c_BW_LEN-1:0]      qlen;
  logic [c_BW_SIZE-1:0]     qsize;
  logic [c_BW_BURST-1:0]    qburst;
  logic [BW_AXI_DATA/8-1:0] qwstrb;
  logic [BW_AXI_DATA-1:0]   qwdata;
  logic [BW_AXI_ADDR-1:0]   qaddr;
  logic [BW_BURDEN-1:0]     qburden;

  logic                     yvalid;
  logic                     yready;
  logic                     ylast;
  logic                     ywreply;
  logic [c_BW_RESP-1:0]     yresp;
  logic [BW_AXI_DATA-1:0]   yrdata;
  logic [BW_BURDEN-1:0]     yburden;

  modport master (
    output qvalid, qlast, qwrite, qlen, qsize, qburst, qwstrb, qwdata, qaddr, qburden,
    input  qready,
    input  yvalid, ylast, ywreply, yresp, yrdata, yburden,
    output yready
  );

  modport slave (
    input  qvalid, qlast, qwrite, qlen, qsize, qburst, qwstrb, qwdata, qaddr, qburden,
    output qready,
    output yvalid, ylast, ywreply, yresp, yrdata, yburden,
    input  yready
  );

endinterface
`default_nettype wire

// File: rtl/dca_xmi_port_arbiter_oscnt.sv
`default_nettype none
// ============================================================
// dca_xmi_port_arbiter_oscnt : per-requester outstanding counter
// Revision: 1.0
// ============================================================
module dca_xmi_port_arbiter_oscnt #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  wire logic clk,
  input  wire logic clear,
  input  wire logic i_inc,
  input  wire logic i_dec,
  input  wire logic i_rsp,
  output logic      o_full,
  output logic      o_zero,
  output logic      o_err
);

  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec_ok;
  logic             w_inc_ok;

  assign o_zero   = (r_cnt == '0);
  assign w_dec_ok = i_dec & ~o_zero;
  assign w_inc_ok = i_inc & ((r_cnt < c_MAX) | w_dec_ok);

  // A final response retiring this cycle frees a slot for a same-cycle beat.
  assign o_full = (r_cnt >= c_MAX) & ~w_dec_ok;
  assign o_err  = i_rsp & o_zero;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_cnt <= '0;
    end else if (w_inc_ok & ~w_dec_ok) begin
      r_cnt <= r_cnt + c_ONE;
    end else if (w_dec_ok & ~w_inc_ok) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dca_xmi_port_arbiter.sv
`default_nettype none
// ============================================================
// dca_xmi_port_arbiter : round-robin two-LSU share of one XMI port
// Revision: 1.0
// ============================================================
module dca_xmi_port_arbiter
  import dca_xmi_port_arbiter_pkg::*;
#(
  parameter int BW_AXI_ADDR     = 32,
  parameter int BW_AXI_DATA     = 32,
  parameter int BW_LPI_BURDEN   = 1,
  parameter int MAX_OUTSTANDING = 8
) (
  input  wire logic               clk,
  input  wire logic               clear,
  dca_xmi_port_arbiter_if.slave   s0,
  dca_xmi_port_arbiter_if.slave   s1,
  dca_xmi_port_arbiter_if.master  m,
  output logic                    busy,
  output logic                    err_unexpected
);

  localparam int c_CNT_W  = f_cnt_width(MAX_OUTSTANDING);
  localparam int c_ID_BIT = f_id_bit(BW_LPI_BURDEN);
  localparam int c_DN_BW  = f_down_burden(BW_LPI_BURDEN);

  arb_state_e r_state;
  arb_state_e w_state_nx;
  logic       r_owner;
  logic       w_owner_nx;
  logic       r_rr_prio;
  logic       w_rr_nx;
  logic       r_err;

  logic w_full0, w_full1, w_zero0, w_zero1, w_err0, w_err1;
  logic w_elig0, w_elig1, w_grant, w_gvalid, w_qlast, w_acc;
  logic w_inc0, w_inc1;
  logic w_rsp_id, w_rsp_hs, w_dec0, w_dec1, w_rsp0, w_rsp1;
  logic [BW_LPI_BURDEN-1:0] w_qburden_up;
  logic [c_DN_BW-1:0]       w_qburden_dn;

  assign w_elig0 = s0.qvalid & ~w_full0;
  assign w_elig1 = s1.qvalid & ~w_full1;

  // While locked the owner keeps the port regardless of its outstanding count.
  always_comb begin
    w_grant  = 1'b0;
    w_gvalid = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_grant  = r_owner;
      w_gvalid = r_owner ? s1.qvalid : s0.qvalid;
    end else begin
      w_gvalid = w_elig0 | w_elig1;
      w_grant  = (w_elig0 & w_elig1) ? r_rr_prio : w_elig1;
    end
  end

  assign w_qlast      = w_grant ? s1.qlast : s0.qlast;
  assign w_acc        = w_gvalid & m.qready;
  assign w_qburden_up = w_grant ? s1.qburden : s0.qburden;
  assign w_qburden_dn = {w_grant, w_qburden_up};

  assign m.qvalid  = w_gvalid;
  assign m.qlast   = w_qlast;
  assign m.qwrite  = w_grant ? s1.qwrite : s0.qwrite;
  assign m.qlen    = w_grant ? s1.qlen   : s0.qlen;
  assign m.qsize   = w_grant ? s1.qsize  : s0.qsize;
  assign m.qburst  = w_grant ? s1.qburst : s0.qburst;
  assign m.qwstrb  = w_grant ? s1.qwstrb : s0.qwstrb;
  assign m.qwdata  = w_grant ? s1.qwdata : s0.qwdata;
  assign m.qaddr   = w_grant ? s1.qaddr  : s0.qaddr;
  assign m.qburden = w_qburden_dn;

  assign s0.qready = m.qready & w_gvalid & ~w_grant;
  assign s1.qready = m.qready & w_gvalid &  w_grant;

  assign w_inc0 = w_acc & w_qlast & ~w_grant;
  assign w_inc1 = w_acc & w_qlast &  w_grant;

  assign w_rsp_id = m.yburden[c_ID_BIT];
  assign m.yready = w_rsp_id ? s1.yready : s0.yready;
  assign w_rsp_hs = m.yvalid & m.yready;
  assign w_rsp0   = w_rsp_hs & ~w_rsp_id;
  assign w_rsp1   = w_rsp_hs &  w_rsp_id;
  assign w_dec0   = w_rsp0 & m.ylast;
  assign w_dec1   = w_rsp1 & m.ylast;

  assign s0.yvalid  = m.yvalid & ~w_rsp_id;
  assign s0.ylast   = m.ylast;
  assign s0.ywreply = m.ywreply;
  assign s0.yresp   = m.yresp;
  assign s0.yrdata  = m.yrdata;
  assign s0.yburden = m.yburden[BW_LPI_BURDEN-1:0];

  assign s1.yvalid  = m.yvalid & w_rsp_id;
  assign s1.ylast   = m.ylast;
  assign s1.ywreply = m.ywreply;
  assign s1.yresp   = m.yresp;
  assign s1.yrdata  = m.yrdata;
  assign s1.yburden = m.yburden[BW_LPI_BURDEN-1:0];

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_rr_nx    = r_rr_prio;
    if (w_acc) begin
      if (w_qlast) begin
        w_state_nx = ST_OPEN;
        w_rr_nx    = ~w_grant;
      end else begin
        w_state_nx = ST_LOCKED;
        w_owner_nx = w_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= ST_OPEN;
      r_owner   <= 1'b0;
      r_rr_prio <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_owner   <= w_owner_nx;
      r_rr_prio <= w_rr_nx;
      if (w_err0 | w_err1) begin
        r_err <= 1'b1;
      end
    end
  end

  dca_xmi_port_arbiter_oscnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (c_CNT_W)
  ) u_oscnt0 (
    .clk    (clk),
    .clear  (clear),
    .i_inc  (w_inc0),
    .i_dec  (w_dec0),
    .i_rsp  (w_rsp0),
    .o_full (w_full0),
    .o_zero (w_zero0),
    .o_err  (w_err0)
  );

  dca_xmi_port_arbiter_oscnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (c_CNT_W)
  ) u_oscnt1 (
    .clk    (clk),
    .clear  (clear),
    .i_inc  (w_inc1),
    .i_dec  (w_dec1),
    .i_rsp  (w_rsp1),
    .o_full (w_full1),
    .o_zero (w_zero1),
    .o_err  (w_err1)
  );

  assign busy           = (r_state == ST_LOCKED) | ~w_zero0 | ~w_zero1;
  assign err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dca_xmi_port_arbiter.sv
`default_nettype none
// ============================================================
// tb_dca_xmi_port_arbiter : directed self-checking bench
// Revision: 1.0
// ============================================================
module tb_dca_xmi_port_arbiter;

  localparam int c_MAX = 2;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic busy;
  logic err_unexpected;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dca_xmi_port_arbiter_if #(.BW_AXI_ADDR(32), .BW_AXI_DATA(32), .BW_BURDEN(1)) s0_if ();
  dca_xmi_port_arbiter_if #(.BW_AXI_ADDR(32), .BW_AXI_DATA(32), .BW_BURDEN(1)) s1_if ();
  dca_xmi_port_arbiter_if #(.BW_AXI_ADDR(32), .BW_AXI_DATA(32), .BW_BURDEN(2)) m_if ();

  dca_xmi_port_arbiter #(
    .BW_AXI_ADDR     (32),
    .BW_AXI_DATA     (32),
    .BW_LPI_BURDEN   (1),
    .MAX_OUTSTANDING (c_MAX)
  ) dut (
    .clk            (clk),
    .clear          (clear),
    .s0             (s0_if),
    .s1             (s1_if),
    .m              (m_if),
    .busy           (busy),
    .err_unexpected (err_unexpected)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    s0_if.qvalid = 0; s0_if.qlast = 0; s0_if.qwrite = 0; s0_if.qlen = 0; s0_if.qsize = 0;
    s0_if.qburst = 0; s0_if.qwstrb = 0; s0_if.qwdata = 0; s0_if.qaddr = 0; s0_if.qburden = 0;
    s0_if.yready = 0;
    s1_if.qvalid = 0; s1_if.qlast = 0; s1_if.qwrite = 0; s1_if.qlen = 0; s1_if.qsize = 0;
    s1_if.qburst = 0; s1_if.qwstrb = 0; s1_if.qwdata = 0; s1_if.qaddr = 0; s1_if.qburden = 0;
    s1_if.yready = 0;
    m_if.qready = 0; m_if.yvalid = 0; m_if.ylast = 0; m_if.ywreply = 0; m_if.yresp = 0;
    m_if.yrdata = 0; m_if.yburden = 0;
  endtask

  task automatic do_reset;
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_unexpected); end
    checks++; if (s0_if.qready !== 1'b0) begin errors++; $display("FAIL reset_s0qready: got %b want 0", s0_if.qready); end
    checks++; if (s1_if.qready !== 1'b0) begin errors++; $display("FAIL reset_s1qready: got %b want 0", s1_if.qready); end
    checks++; if (m_if.qvalid !== 1'b0) begin errors++; $display("FAIL reset_mqvalid: got %b want 0", m_if.qvalid); end
    checks++; if ({s0_if.yvalid, s1_if.yvalid} !== 2'b00) begin errors++; $display("FAIL reset_yvalid: got %b want 00", {s0_if.yvalid, s1_if.yvalid}); end
    s0_if.qvalid = 1; s0_if.qlast = 1; m_if.qready = 1;
    #1;
    checks++; if (s0_if.qready !== 1'b1) begin errors++; $display("FAIL reset_s0qready_req: got %b want 1", s0_if.qready); end
    idle();
  endtask

  task automatic test_rr_tie;
    do_reset();
    s0_if.qvalid = 1; s0_if.qlast = 1; s0_if.qaddr = 32'h100; s0_if.qburden = 1'b0;
    s1_if.qvalid = 1; s1_if.qlast = 1; s1_if.qaddr = 32'h200; s1_if.qburden = 1'b1;
    m_if.qready = 1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = k[0];
      #1;
      checks++; if (m_if.qburden !== {exp_id, exp_id}) begin errors++; $display("FAIL rr_burden_%0d: got %b want %b", k, m_if.qburden, {exp_id, exp_id}); end
      checks++; if (m_if.qaddr !== (exp_id ? 32'h200 : 32'h100)) begin errors++; $display("FAIL rr_addr_%0d: got %h", k, m_if.qaddr); end
      checks++; if (s0_if.qready !== ~exp_id) begin errors++; $display("FAIL rr_s0qready_%0d: got %b want %b", k, s0_if.qready, ~exp_id); end
      tick();
    end
    #1;
    checks++; if (m_if.qvalid !== 1'b0) begin errors++; $display("FAIL rr_full_mqvalid: got %b want 0", m_if.qvalid); end
    checks++; if ({s0_if.qready, s1_if.qready} !== 2'b00) begin errors++; $display("FAIL rr_full_qready: got %b want 00", {s0_if.qready, s1_if.qready}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy: got %b want 1", busy); end
    idle();
  endtask

  task automatic test_burst_lock;
    do_reset();
    m_if.qready = 1;
    s0_if.qvalid = 1; s0_if.qlast = 1; s0_if.qaddr = 32'h10;
    tick();
    // rr_prio now favours s1, so only the lock keeps s0 on the port.
    s0_if.qwrite = 1; s0_if.qlen = 8'd3; s0_if.qaddr = 32'h40; s0_if.qwstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      s0_if.qwdata = 32'hA0 + k;
      s0_if.qlast  = (k == 3);
      if (k == 1) begin
        s1_if.qvalid = 1; s1_if.qlast = 1; s1_if.qaddr = 32'h300; s1_if.qburden = 1'b1;
      end
      #1;
      checks++; if (m_if.qburden[1] !== 1'b0) begin errors++; $display("FAIL burst_id_%0d: got %b want 0", k, m_if.qburden[1]); end
      checks++; if (m_if.qwdata !== 32'hA0 + k) begin errors++; $display("FAIL burst_data_%0d: got %h want %h", k, m_if.qwdata, 32'hA0 + k); end
      checks++; if (s1_if.qready !== 1'b0) begin errors++; $display("FAIL burst_s1qready_%0d: got %b want 0", k, s1_if.qready); end
      if (k == 2) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b want 1", busy); end
      end
      tick();
    end
    s0_if.qvalid = 0;
    #1;
    checks++; if (m_if.qburden !== 2'b11) begin errors++; $display("FAIL burst_after_burden: got %b want 11", m_if.qburden); end
    checks++; if (s1_if.qready !== 1'b1) begin errors++; $display("FAIL burst_after_s1qready: got %b want 1", s1_if.qready); end
    checks++; if (m_if.qaddr !== 32'h300) begin errors++; $display("FAIL burst_after_addr: got %h want 300", m_if.qaddr); end
    idle();
  endtask

  task automatic test_throttle;
    do_reset();
    m_if.qready = 1;
    s1_if.qvalid = 1; s1_if.qlast = 1; s1_if.qburden = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (s1_if.qready !== 1'b1) begin errors++; $display("FAIL thr_accept_%0d: got %b want 1", k, s1_if.qready); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (s1_if.qready !== 1'b0) begin errors++; $display("FAIL thr_stall_%0d: got %b want 0", k, s1_if.qready); end
      checks++; if (m_if.qvalid !== 1'b0) begin errors++; $display("FAIL thr_mqvalid_%0d: got %b want 0", k, m_if.qvalid); end
      tick();
    end
    m_if.yvalid = 1; m_if.ylast = 1; m_if.yburden = 2'b10; m_if.yrdata = 32'h55;
    s1_if.yready = 1;
    #1;
    checks++; if (s1_if.qready !== 1'b1) begin errors++; $display("FAIL thr_same_cycle: got %b want 1", s1_if.qready); end
    checks++; if (m_if.yready !== 1'b1) begin errors++; $display("FAIL thr_myready: got %b want 1", m_if.yready); end
    tick();
    m_if.yvalid = 0;
    #1;
    checks++; if (s1_if.qready !== 1'b0) begin errors++; $display("FAIL thr_restall: got %b want 0", s1_if.qready); end
    idle();
  endtask

  task automatic test_resp_route;
    do_reset();
    m_if.qready = 1;
    s0_if.qvalid = 1; s0_if.qlast = 1;
    s1_if.qvalid = 1; s1_if.qlast = 1;
    tick(); tick(); tick();
    s0_if.qvalid = 0; s1_if.qvalid = 0;
    m_if.yvalid = 1; m_if.ylast = 1; m_if.yburden = 2'b00; m_if.yrdata = 32'h11;
    s0_if.yready = 0; s1_if.yready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (m_if.yready !== 1'b0) begin errors++; $display("FAIL route_hold_myready_%0d: got %b want 0", k, m_if.yready); end
      checks++; if ({s0_if.yvalid, s1_if.yvalid} !== 2'b10) begin errors++; $display("FAIL route_hold_yvalid_%0d: got %b want 10", k, {s0_if.yvalid, s1_if.yvalid}); end
      tick();
    end
    s0_if.yready = 1;
    #1;
    checks++; if (m_if.yready !== 1'b1) begin errors++; $display("FAIL route0_myready: got %b want 1", m_if.yready); end
    checks++; if (s0_if.yrdata !== 32'h11 || s0_if.yburden !== 1'b0) begin errors++; $display("FAIL route0_fields: got %h/%b want 11/0", s0_if.yrdata, s0_if.yburden); end
    tick();
    m_if.yburden = 2'b11; m_if.yrdata = 32'h22; s0_if.yready = 0; s1_if.yready = 1;
    #1;
    checks++; if ({s0_if.yvalid, s1_if.yvalid} !== 2'b01) begin errors++; $display("FAIL route1_yvalid: got %b want 01", {s0_if.yvalid, s1_if.yvalid}); end
    checks++; if (s1_if.yburden !== 1'b1 || s1_if.yrdata !== 32'h22) begin errors++; $display("FAIL route1_fields: got %b/%h want 1/22", s1_if.yburden, s1_if.yrdata); end
    checks++; if (m_if.yready !== 1'b1) begin errors++; $display("FAIL route1_myready: got %b want 1", m_if.yready); end
    tick();
    m_if.yburden = 2'b01; m_if.yrdata = 32'h33; s0_if.yready = 1; s1_if.yready = 0;
    #1;
    checks++; if ({s0_if.yvalid, s1_if.yvalid} !== 2'b10) begin errors++; $display("FAIL route2_yvalid: got %b want 10", {s0_if.yvalid, s1_if.yvalid}); end
    checks++; if (s0_if.yburden !== 1'b1) begin errors++; $display("FAIL route2_burden: got %b want 1", s0_if.yburden); end
    checks++; if (m_if.yready !== 1'b1) begin errors++; $display("FAIL route2_myready: got %b want 1", m_if.yready); end
    tick();
    m_if.yvalid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL route_busy_drained: got %b want 0", busy); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL route_err: got %b want 0", err_unexpected); end
    idle();
  endtask

  task automatic test_err;
    do_reset();
    m_if.yvalid = 1; m_if.ylast = 1; m_if.yburden = 2'b10; s1_if.yready = 1;
    #1;
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL err_before_edge: got %b want 0", err_unexpected); end
    tick();
    m_if.yvalid = 0;
    #1;
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_unexpected); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_cnt_stays0: got %b want 0", busy); end
    tick(); tick();
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_unexpected); end
    m_if.qready = 1; s1_if.qvalid = 1; s1_if.qlast = 1;
    #1;
    checks++; if (s1_if.qready !== 1'b1) begin errors++; $display("FAIL err_no_underflow: got %b want 1", s1_if.qready); end
    do_reset();
    #1;
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err_unexpected); end
  endtask

  task automatic test_clear_mid_burst;
    do_reset();
    m_if.qready = 1;
    s1_if.qvalid = 1; s1_if.qwrite = 1; s1_if.qlen = 8'd3; s1_if.qlast = 0; s1_if.qburden = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_before: got %b want 1", busy); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    s1_if.qwrite = 0; s1_if.qlast = 1;
    s0_if.qvalid = 1; s0_if.qlast = 1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_after: got %b want 0", busy); end
    checks++; if (m_if.qburden[1] !== 1'b0) begin errors++; $display("FAIL clr_tie_id: got %b want 0", m_if.qburden[1]); end
    checks++; if ({s0_if.qready, s1_if.qready} !== 2'b10) begin errors++; $display("FAIL clr_tie_qready: got %b want 10", {s0_if.qready, s1_if.qready}); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_rr_tie();
    test_burst_lock();
    test_throttle();
    test_resp_route();
    test_err();
    test_clear_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
